// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative 32-bit multiply/divide unit with architectural HI/LO.
//
// Computes MIPS-style MULT/MULTU/DIV/DIVU one bit per cycle. Signed operations
// are done on magnitudes, and the sign is applied in a final FIX cycle. The
// latency is fixed at 34 cycles from the edge that samples start to the cycle
// in which done is high. MTHI/MTLO writes are accepted only in IDLE.
//
// Ports:
//   clock  in   1   rising-edge clock
//   reset  in   1   synchronous active-high reset
//   start  in   1   launch an operation (sampled only in IDLE)
//   op     in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   srca   in  32   multiplicand / dividend
//   srcb   in  32   multiplier / divisor
//   wr_hi  in   1   MTHI strobe
//   wr_lo  in   1   MTLO strobe
//   wdata  in  32   MTHI/MTLO data
//   busy   out  1   operation in progress (CALC or FIX)
//   done   out  1   one-cycle pulse: hi/lo hold a fresh result
//   hi     out 32   HI register (product high / remainder)
//   lo     out 32   LO register (product low / quotient)
module muldiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [4:0]  count_reg, count_next;
  // Multiply: {partial product high, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  logic [63:0] acc_reg, acc_next;
  // Magnitude added each multiply step, or the divisor magnitude.
  logic [31:0] opb_reg, opb_next;
  // Untouched dividend, needed for the divide-by-zero result.
  logic [31:0] raw_a_reg, raw_a_next;
  logic        is_div_reg, is_div_next;
  logic        neg_res_reg, neg_res_next;
  logic        neg_rem_reg, neg_rem_next;
  logic        div_zero_reg, div_zero_next;
  logic        div_ovf_reg, div_ovf_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic        done_reg, done_next;

  // Operand magnitudes at launch; op[0]=0 selects the signed variants.
  logic        signed_op;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  assign signed_op = ~op[0];
  assign mag_a     = (signed_op && srca[31]) ? (~srca + 32'd1) : srca;
  assign mag_b     = (signed_op && srcb[31]) ? (~srcb + 32'd1) : srcb;

  // One shift-add multiply step: add the multiplicand to the high half when
  // the current multiplier LSB is set, then shift the whole accumulator right.
  logic [32:0] mul_sum;
  logic [63:0] mul_acc;

  assign mul_sum = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opb_reg} : 33'd0);
  assign mul_acc = {mul_sum, acc_reg[31:1]};

  // One restoring-division step on a 33-bit shifted remainder. When the trial
  // subtraction succeeds the true difference is below the divisor, so the low
  // 32 bits of a 32-bit subtraction are exact.
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] div_acc;

  assign div_shift = {acc_reg[63:32], acc_reg[31]};
  assign div_ge    = (div_shift >= {1'b0, opb_reg});
  assign div_diff  = div_shift[31:0] - opb_reg;
  assign div_acc   = div_ge ? {div_diff, acc_reg[30:0], 1'b1}
                            : {div_shift[31:0], acc_reg[30:0], 1'b0};

  // Sign fix-up applied in the FIX cycle.
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign prod_fix = neg_res_reg ? (~acc_reg + 64'd1) : acc_reg;
  assign quo_fix  = neg_res_reg ? (~acc_reg[31:0] + 32'd1) : acc_reg[31:0];
  assign rem_fix  = neg_rem_reg ? (~acc_reg[63:32] + 32'd1) : acc_reg[63:32];

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    acc_next      = acc_reg;
    opb_next      = opb_reg;
    raw_a_next    = raw_a_reg;
    is_div_next   = is_div_reg;
    neg_res_next  = neg_res_reg;
    neg_rem_next  = neg_rem_reg;
    div_zero_next = div_zero_reg;
    div_ovf_next  = div_ovf_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          // start takes priority; a same-cycle MTHI/MTLO is dropped.
          state_next    = CALC;
          count_next    = 5'd0;
          is_div_next   = op[1];
          raw_a_next    = srca;
          neg_res_next  = signed_op && (srca[31] ^ srcb[31]);
          neg_rem_next  = signed_op && srca[31];
          div_zero_next = op[1] && (srcb == 32'd0);
          div_ovf_next  = (op == 2'b10) && (srca == 32'h8000_0000) &&
                          (srcb == 32'hFFFF_FFFF);
          if (op[1]) begin
            acc_next = {32'd0, mag_a};
            opb_next = mag_b;
          end else begin
            acc_next = {32'd0, mag_b};
            opb_next = mag_a;
          end
        end else begin
          if (wr_hi) hi_next = wdata;
          if (wr_lo) lo_next = wdata;
        end
      end

      CALC: begin
        acc_next   = is_div_reg ? div_acc : mul_acc;
        count_next = count_reg + 5'd1;
        if (count_reg == 5'd31) begin
          state_next = FIX;
        end
      end

      FIX: begin
        state_next = IDLE;
        done_next  = 1'b1;
        if (is_div_reg) begin
          if (div_zero_reg) begin
            hi_next = raw_a_reg;
            lo_next = 32'hFFFF_FFFF;
          end else if (div_ovf_reg) begin
            hi_next = 32'd0;
            lo_next = 32'h8000_0000;
          end else begin
            hi_next = rem_fix;
            lo_next = quo_fix;
          end
        end else begin
          hi_next = prod_fix[63:32];
          lo_next = prod_fix[31:0];
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= 5'd0;
      acc_reg      <= 64'd0;
      opb_reg      <= 32'd0;
      raw_a_reg    <= 32'd0;
      is_div_reg   <= 1'b0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
      div_ovf_reg  <= 1'b0;
      hi_reg       <= 32'd0;
      lo_reg       <= 32'd0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      acc_reg      <= acc_next;
      opb_reg      <= opb_next;
      raw_a_reg    <= raw_a_next;
      is_div_reg   <= is_div_next;
      neg_res_reg  <= neg_res_next;
      neg_rem_reg  <= neg_rem_next;
      div_zero_reg <= div_zero_next;
      div_ovf_reg  <= div_ovf_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      done_reg     <= done_next;
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed and random checks of muldiv_unit.
// Expected HI/LO values are pushed to a scoreboard when an operation is
// launched and popped when done pulses. Inputs change and outputs are sampled
// 1 ns after the rising edge.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_unit dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .srca  (srca),
    .srcb  (srcb),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t        scoreboard[$];
  int          compared   = 0;
  int          mismatched = 0;
  // Architectural HI/LO as the bench expects them right now.
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      $error("%s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference behaviour, written from the instruction definitions.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    int          sa;
    int          sbv;
    sa  = a;
    sbv = b;
    case (o)
      2'b00: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p;
      end
      2'b01: begin
        p = {32'd0, a} * {32'd0, b};
        return p;
      end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sbv), 32'(sa / sbv)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic expect_result(input string name, input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    e.hi   = eh;
    e.lo   = el;
    e.name = name;
    scoreboard.push_back(e);
  endtask

  // Drive start for the edge that becomes cycle 0.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic lo_wr, input logic [31:0] wd);
    op    = o;
    srca  = a;
    srcb  = b;
    wr_lo = lo_wr;
    wdata = wd;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wr_lo = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("done_after_start", {63'd0, done}, 64'd0);
  endtask

  // mode 0: quiet, 1: scramble operands every cycle, 2: start+wr_lo poke at cycle 5.
  // done is expected in the cycle that ends at edge 34, i.e. 33 edges after cycle 0.
  task automatic wait_result(input int mode);
    int   n;
    int   busy_cnt;
    exp_t e;
    n        = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) busy_cnt++;
      if (n == 16) begin
        check("hold_hi_in_calc", {32'd0, hi}, {32'd0, cur_hi});
        check("hold_lo_in_calc", {32'd0, lo}, {32'd0, cur_lo});
      end
      if (mode == 1) begin
        srca = $urandom;
        srcb = $urandom;
      end
      if (mode == 2 && n == 4) begin
        start = 1'b1;
        wr_lo = 1'b1;
        wdata = 32'h0000_1234;
      end
      if (mode == 2 && n == 5) begin
        start = 1'b0;
        wr_lo = 1'b0;
      end
      @(posedge clock); #1;
      n++;
    end
    check("latency_edges", 64'(n), 64'd33);
    check("busy_cycles", 64'(busy_cnt), 64'd33);
    check("busy_low_at_done", {63'd0, busy}, 64'd0);
    if (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      check({e.name, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
      check({e.name, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
      $display("op %s: hi=%08h lo=%08h (expected %08h %08h)", e.name, hi, lo, e.hi, e.lo);
      cur_hi = e.hi;
      cur_lo = e.lo;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int mode);
    expect_result(name, eh, el);
    launch(o, a, b, 1'b0, 32'd0);
    wait_result(mode);
  endtask

  initial begin
    logic [63:0] m;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          pulses;

    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    srca  = 32'd0;
    srcb  = 32'd0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    wdata = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    $display("reset: busy=%0b done=%0b hi=%08h lo=%08h", busy, done, hi, lo);
    reset = 1'b0;
    @(posedge clock); #1;

    // Directed operations, launched back to back where possible.
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    run_op("mult_min_sq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 0);
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("divu_by0", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);
    run_op("divu_scramble", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1);
    run_op("mult_poke", 2'b00, 32'd123, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FF0A, 2);

    // start together with MTLO: the write is dropped.
    expect_result("divu_start_wrlo", 32'd0, 32'd10);
    launch(2'b11, 32'd50, 32'd5, 1'b1, 32'hDEAD_BEEF);
    check("wrlo_dropped_at_start", {32'd0, lo}, {32'd0, cur_lo});
    wait_result(0);

    // MTHI / MTLO / both in IDLE.
    @(posedge clock); #1;
    check("done_single_pulse", {63'd0, done}, 64'd0);
    wdata = 32'hAAAA_AAAA;
    wr_hi = 1'b1;
    @(posedge clock); #1;
    wr_hi  = 1'b0;
    cur_hi = 32'hAAAA_AAAA;
    check("mthi_hi", {32'd0, hi}, {32'd0, cur_hi});
    check("mthi_lo_kept", {32'd0, lo}, {32'd0, cur_lo});
    $display("mthi: hi=%08h lo=%08h", hi, lo);
    wdata = 32'h5555_5555;
    wr_lo = 1'b1;
    @(posedge clock); #1;
    wr_lo  = 1'b0;
    cur_lo = 32'h5555_5555;
    check("mtlo_lo", {32'd0, lo}, {32'd0, cur_lo});
    check("mtlo_hi_kept", {32'd0, hi}, {32'd0, cur_hi});
    $display("mtlo: hi=%08h lo=%08h", hi, lo);
    wdata = 32'h0F0F_0F0F;
    wr_hi = 1'b1;
    wr_lo = 1'b1;
    @(posedge clock); #1;
    wr_hi  = 1'b0;
    wr_lo  = 1'b0;
    cur_hi = 32'h0F0F_0F0F;
    cur_lo = 32'h0F0F_0F0F;
    check("mthilo_hi", {32'd0, hi}, {32'd0, cur_hi});
    check("mthilo_lo", {32'd0, lo}, {32'd0, cur_lo});
    $display("mthi+mtlo: hi=%08h lo=%08h", hi, lo);

    // Reset sampled at edge 10 of a MULTU aborts it.
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0);
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset  = 1'b0;
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) pulses++;
      @(posedge clock); #1;
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    $display("abort: busy=%0b hi=%08h lo=%08h done_pulses=%0d", busy, hi, lo, pulses);

    // Recovery after the abort.
    run_op("multu_recover", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 0);

    // Random operations against the reference model, back to back.
    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2 == 1) ? 32'($urandom_range(0, 9)) : $urandom;
      m  = model(ro, ra, rb);
      run_op("random", ro, ra, rb, m[63:32], m[31:0], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit in the execute stage, directly downstream of the register file read ports. It consumes the two source operands, computes MIPS-style MULT/MULTU/DIV/DIVU results into the architectural HI/LO pair, and reports `busy` to the hazard logic so dependent instructions stall. It also supports direct HI/LO writes (MTHI/MTLO).

## Interface
- No parameters; data width is fixed at 32.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  launch an operation; sampled only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `srca`  in  32  register file port A data (multiplicand / dividend).
- `srcb`  in  32  register file port B data (multiplier / divisor).
- `wr_hi`  in  1  MTHI strobe.
- `wr_lo`  in  1  MTLO strobe.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in progress; new `start` and HI/LO writes are ignored.
- `done`  out  1  one-cycle pulse; `hi`/`lo` hold the new result.
- `hi`  out  32  HI register (product high / remainder).
- `lo`  out  32  LO register (product low / quotient).

## Operation
- Reset (synchronous, active-high) takes effect at the next rising edge: state=IDLE, `busy`=0, `done`=0, `hi`=`lo`=0, iteration counter=0.
- States and transitions:
  - IDLE → CALC on `start`.
  - CALC runs 32 iterations, then goes to FIX.
  - FIX → IDLE unconditionally.
- IDLE with `start`=1:
  - Latch `op`, `srca` and `srcb` internally. Later changes on the register file outputs have no effect.
  - For signed ops, latch the operand magnitudes and record the result signs.
- CALC, multiply: radix-2 shift-add on unsigned magnitudes into a 64-bit accumulator, one bit per cycle.
- CALC, divide: restoring division on unsigned magnitudes, one quotient bit per cycle, 33-bit partial remainder.
- FIX, signed multiply: negate the 64-bit product (two's complement) if the operand signs differ.
- FIX, signed divide:
  - Negate the quotient if the operand signs differ.
  - The remainder takes the sign of the dividend.
- FIX writes `hi`/`lo`. Both hold their previous values for the whole of CALC.
- Divide by zero (DIV or DIVU): `lo`=0xFFFF_FFFF, `hi`=latched `srca`, regardless of sign.
- Signed overflow, 0x8000_0000 / 0xFFFF_FFFF: `lo`=0x8000_0000, `hi`=0.
- `wr_hi`/`wr_lo` in IDLE without `start`: `hi`/`lo` take `wdata` at the edge. Both strobes together write both registers.
- `start` together with `wr_hi`/`wr_lo` in IDLE: `start` wins and the write is dropped.
- Any `start`, `wr_hi` or `wr_lo` while `busy`=1 is ignored. No queueing.
- `reset` asserted mid-operation aborts the operation. No `done` is produced and `hi`/`lo` are cleared.

## Timing
- Cycle 0 is the edge at which `start` is sampled in IDLE.
- `busy`=1 from cycle 1 through cycle 33: 32 CALC cycles plus 1 FIX cycle.
- At cycle 34, `busy`=0, `done`=1 for exactly one cycle, and `hi`/`lo` are valid. The latency is 34 cycles.
- A new `start` is accepted at cycle 34, when `done` is high. Back-to-back operations are therefore 34 cycles apart.
- The latency is fixed for all ops and operands, including divide by zero.
- MTHI/MTLO latency is 1 cycle.
- `done` and `busy` are never high in the same cycle.

## Test plan
- Reset, then MULTU with `srca`=0xFFFF_FFFF, `srcb`=0xFFFF_FFFF → at cycle 34, `done`=1, `hi`=0xFFFF_FFFE, `lo`=0x0000_0001. `busy` is high for exactly 33 cycles.
- MULT with -3 × 5 → `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFF1.
- MULT with 0x8000_0000 × 0x8000_0000 → `hi`=0x4000_0000, `lo`=0.
- DIV with -7 / 2 → `lo`=0xFFFF_FFFD, `hi`=0xFFFF_FFFF.
- DIVU with 7 / 0 → `lo`=0xFFFF_FFFF, `hi`=7.
- DIV with 0x8000_0000 / 0xFFFF_FFFF → `lo`=0x8000_0000, `hi`=0.
- Operand stability: start DIVU 100/7, then change `srca`/`srcb` every cycle → result is `lo`=14, `hi`=2.
- Ignored requests while busy: pulse `start` and `wr_lo` (`wdata`=0x1234) at cycle 5 → both are ignored, and `done` occurs only at cycle 34.
- MTHI/MTLO in IDLE: write `hi`=0xAAAA_AAAA → visible next cycle.
- Same-cycle `wr_lo` and `start` → `lo` shows only the operation result.
- Reset mid-operation: assert `reset` at cycle 10 of a MULTU → the next cycle has `busy`=0, `hi`=`lo`=0, and `done` never pulses.
- Recovery: a fresh `start` after the reset completes normally.
